// File: rtl/mem_pkg.sv
// Shared types and helpers for the word-to-byte SRAM bridge: FSM states,
// SRAM geometry and the lane-selection function over a write mask.
package mem_pkg;

  localparam int LANES   = 4;
  localparam int SRAM_AW = 15;
  localparam int WORD_AW = SRAM_AW - 2;

  typedef logic [1:0] lane_t;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    RESP
  } state_t;

  typedef struct packed {
    logic  found;
    lane_t idx;
  } lane_sel_t;

  // Lowest set lane of the mask; callers pre-mask lanes already written.
  function automatic lane_sel_t next_set_lane(input logic [LANES-1:0] mask);
    lane_sel_t sel;
    sel = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask[i]) begin
        sel.found = 1'b1;
        sel.idx   = lane_t'(i);
      end
    end
    return sel;
  endfunction

  function automatic logic [7:0] lane_byte(input logic [31:0] w, input lane_t l);
    return w[{l, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/sram_phase_ctr.sv
// Loadable down-counter timing the SRAM read-wait and write-pulse dwell;
// done_o is high whenever the count has reached zero.
module sram_phase_ctr #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/sram_word_bridge.sv
// Turns one 32-bit LSU request into a sequence of byte accesses on an async
// 32Kx8 SRAM. Optional address-error reporting: define SRAM_BRIDGE_ERR_EN.
module sram_word_bridge
  import mem_pkg::*;
#(
  parameter int READ_WAIT = 1,
  parameter int WE_PULSE  = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic [31:0]        i_req_addr,
  input  logic               i_req_wen,
  input  logic [31:0]        i_req_wdata,
  input  logic [3:0]         i_req_wmask,
  output logic               o_rsp_valid,
`ifdef SRAM_BRIDGE_ERR_EN
  output logic               o_rsp_err,
`endif
  output logic [31:0]        o_rsp_rdata,
  output logic [SRAM_AW-1:0] o_sram_addr,
  output logic [7:0]         o_sram_dq_out,
  output logic               o_sram_dq_oe,
  input  logic [7:0]         i_sram_dq_in,
  output logic               o_sram_ce_n,
  output logic               o_sram_oe_n,
  output logic               o_sram_we_n
);

  localparam int CTR_W = 8;
  localparam logic [CTR_W-1:0] RD_LOAD = CTR_W'(READ_WAIT);
  localparam logic [CTR_W-1:0] WP_LOAD = CTR_W'(WE_PULSE - 1);

  state_t               state_q;
  lane_t                lane_q;
  logic                 ready_q;
  logic                 rsp_valid_q;
  logic [31:0]          rdata_q;
  logic [SRAM_AW-1:0]   sram_addr_q;
  logic [7:0]           dq_out_q;
  logic                 dq_oe_q;
  logic                 ce_n_q;
  logic                 oe_n_q;
  logic                 we_n_q;

  logic [WORD_AW-1:0]   word_q;
  logic [31:0]          wdata_q;
  logic [3:0]           mask_q;
  logic [23:0]          rbuf_q;

  logic                 accept;
  logic                 req_err;
  logic                 phase_done;
  logic                 ctr_load;
  logic [CTR_W-1:0]     ctr_val;
  lane_sel_t            first_sel;
  lane_sel_t            next_sel;

  assign accept = i_req_valid & ready_q;

`ifdef SRAM_BRIDGE_ERR_EN
  logic rsp_err_q;
  assign req_err   = (|i_req_addr[31:15]) | (|i_req_addr[1:0]);
  assign o_rsp_err = rsp_err_q;
`else
  logic unused_addr_bits;
  assign req_err          = 1'b0;
  assign unused_addr_bits = ^{i_req_addr[31:15], i_req_addr[1:0]};
`endif

  assign first_sel = next_set_lane(i_req_wmask);
  assign next_sel  = next_set_lane(mask_q & (4'b1110 << lane_q));

  // Reload at the start of every read lane and every write pulse.
  always_comb begin
    ctr_load = 1'b0;
    ctr_val  = RD_LOAD;
    case (state_q)
      IDLE:     ctr_load = accept & ~i_req_wen & ~req_err;
      RD:       ctr_load = phase_done & (lane_q != 2'd3);
      WR_SETUP: begin
        ctr_load = 1'b1;
        ctr_val  = WP_LOAD;
      end
      default:  ctr_load = 1'b0;
    endcase
  end

  sram_phase_ctr #(
    .W (CTR_W)
  ) u_phase_ctr (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .load_i     (ctr_load),
    .load_val_i (ctr_val),
    .done_o     (phase_done)
  );

  // Request payload and partial read word carry no reset.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      word_q  <= i_req_addr[14:2];
      wdata_q <= i_req_wdata;
      mask_q  <= i_req_wmask;
    end
    if (state_q == RD && phase_done && lane_q != 2'd3) begin
      rbuf_q[{lane_q, 3'b000} +: 8] <= i_sram_dq_in;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      lane_q      <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
`ifdef SRAM_BRIDGE_ERR_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
`ifdef SRAM_BRIDGE_ERR_EN
      rsp_err_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            ready_q <= 1'b0;
            if (req_err) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rdata_q     <= '0;
`ifdef SRAM_BRIDGE_ERR_EN
              rsp_err_q   <= 1'b1;
`endif
            end else if (!i_req_wen) begin
              state_q     <= RD;
              lane_q      <= '0;
              ce_n_q      <= 1'b0;
              oe_n_q      <= 1'b0;
              dq_oe_q     <= 1'b0;
              sram_addr_q <= {i_req_addr[14:2], 2'b00};
            end else if (first_sel.found) begin
              state_q     <= WR_SETUP;
              lane_q      <= first_sel.idx;
              ce_n_q      <= 1'b0;
              dq_oe_q     <= 1'b1;
              dq_out_q    <= lane_byte(i_req_wdata, first_sel.idx);
              sram_addr_q <= {i_req_addr[14:2], first_sel.idx};
            end else begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rdata_q     <= '0;
            end
          end
        end
        RD: begin
          if (phase_done) begin
            if (lane_q == 2'd3) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rdata_q     <= {i_sram_dq_in, rbuf_q};
              ce_n_q      <= 1'b1;
              oe_n_q      <= 1'b1;
            end else begin
              lane_q      <= lane_q + 2'd1;
              sram_addr_q <= {word_q, lane_q + 2'd1};
            end
          end
        end
        WR_SETUP: begin
          state_q <= WR_PULSE;
          we_n_q  <= 1'b0;
        end
        WR_PULSE: begin
          if (phase_done) begin
            state_q <= WR_HOLD;
            we_n_q  <= 1'b1;
          end
        end
        WR_HOLD: begin
          // Unmasked lanes are skipped outright rather than idled through.
          if (next_sel.found) begin
            state_q     <= WR_SETUP;
            lane_q      <= next_sel.idx;
            dq_out_q    <= lane_byte(wdata_q, next_sel.idx);
            sram_addr_q <= {word_q, next_sel.idx};
          end else begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rdata_q     <= '0;
            ce_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
          end
        end
        RESP: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_req_ready   = ready_q;
  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_rdata   = rdata_q;
  assign o_sram_addr   = sram_addr_q;
  assign o_sram_dq_out = dq_out_q;
  assign o_sram_dq_oe  = dq_oe_q;
  assign o_sram_ce_n   = ce_n_q;
  assign o_sram_oe_n   = oe_n_q;
  assign o_sram_we_n   = we_n_q;

endmodule
